// File: rtl/axi_cmd_splitter_if.sv
// Command input and AXI4 read-address channel of axi_cmd_splitter.
// master = splitter side, slave = command source plus AXI interconnect side.
interface axi_cmd_splitter_if #(
   parameter int AXI_ID_WD   = 2,
   parameter int AXI_ADDR_WD = 16
);
   logic                   cmd_valid;
   logic [AXI_ADDR_WD-1:0] cmd_addr;
   logic [AXI_ID_WD-1:0]   cmd_id;
   logic [1:0]             cmd_burst;
   logic [2:0]             cmd_size;
   logic [AXI_ADDR_WD-1:0] cmd_len;
   logic                   cmd_ready;
   logic                   cmd_abort;
   logic                   cmd_done;

   logic                   ARVALID;
   logic [AXI_ADDR_WD-1:0] ARADDR;
   logic [AXI_ID_WD-1:0]   ARID;
   logic [7:0]             ARLEN;
   logic [2:0]             ARSIZE;
   logic [1:0]             ARBURST;
   logic                   ARREADY;

   modport master (
      input  cmd_valid, cmd_addr, cmd_id, cmd_burst, cmd_size, cmd_len, ARREADY,
      output cmd_ready, cmd_abort, cmd_done,
             ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_id, cmd_burst, cmd_size, cmd_len, ARREADY,
      input  cmd_ready, cmd_abort, cmd_done,
             ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST
   );
endinterface

// File: rtl/axi_cmd_splitter.sv
// axi_cmd_splitter: issues one DMA read command as AXI4 AR bursts, split at
// MAX_BURST_LEN beats (16 for FIXED) and at every 4 KB boundary.
module axi_cmd_splitter #(
   parameter int AXI_ID_WD     = 2,
   parameter int AXI_DATA_WD   = 32,
   parameter int AXI_ADDR_WD   = 16,
   parameter int AXI_STRB_WD   = 4,
   parameter int MAX_BURST_LEN = 256
) (
   input logic                AXI_ACLK,
   input logic                AXI_ARESET,
   axi_cmd_splitter_if.master bus
);
   localparam int         BEAT_BYTES = (AXI_STRB_WD < AXI_DATA_WD / 8) ? AXI_STRB_WD
                                                                       : AXI_DATA_WD / 8;
   localparam logic [2:0] SIZE_MAX   = 3'($clog2(BEAT_BYTES));
   localparam logic [8:0] MAX_N      = 9'(MAX_BURST_LEN);
   localparam logic [8:0] FIXED_N    = 9'd16;
   localparam int         PADW       = AXI_ADDR_WD - 9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_ISSUE = 2'd2,
      S_ABORT = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_cmd_ready;
   logic                   r_cmd_abort;
   logic                   r_arvalid;
   logic                   r_last;
   logic [AXI_ADDR_WD-1:0] r_addr;
   logic [AXI_ADDR_WD-1:0] r_rem;
   logic [AXI_ID_WD-1:0]   r_id;
   logic [1:0]             r_burst;
   logic [2:0]             r_size;
   logic [8:0]             r_n;
   logic [7:0]             r_arlen;

   logic                   w_accept;
   logic                   w_hs;
   logic                   w_bad;
   logic [AXI_ADDR_WD-1:0] w_aligned;
   logic [12:0]            w_bound;
   logic [8:0]             w_lim;
   logic [8:0]             w_n;
   logic [AXI_ADDR_WD-1:0] w_step;
   logic [AXI_ADDR_WD-1:0] w_next_addr;

   // Burst sizing: boundary term is measured from the size-aligned address.
   always_comb begin
      w_aligned = r_addr & ({AXI_ADDR_WD{1'b1}} << r_size);
      w_bound   = (13'h1000 - {1'b0, w_aligned[11:0]}) >> r_size;
      if (r_burst[0]) begin
         if (w_bound < {4'b0000, MAX_N}) begin
            w_lim = w_bound[8:0];
         end else begin
            w_lim = MAX_N;
         end
      end else begin
         w_lim = FIXED_N;
      end
      if (r_rem < {{PADW{1'b0}}, w_lim}) begin
         w_n = r_rem[8:0];
      end else begin
         w_n = w_lim;
      end
      w_step = {{PADW{1'b0}}, r_n} << r_size;
      if (r_burst[0]) begin
         w_next_addr = w_aligned + w_step;
      end else begin
         w_next_addr = r_addr;
      end
   end

   assign w_bad = (bus.cmd_len == {AXI_ADDR_WD{1'b0}}) || bus.cmd_burst[1] ||
                  (bus.cmd_size > SIZE_MAX);

   // Next-state logic.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_hs     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid && r_cmd_ready) begin
               w_accept = 1'b1;
               if (w_bad) begin
                  w_next = S_ABORT;
               end else begin
                  w_next = S_CALC;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CALC: begin
            w_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (r_arvalid && bus.ARREADY) begin
               w_hs = 1'b1;
               if (r_last) begin
                  w_next = S_IDLE;
               end else begin
                  w_next = S_CALC;
               end
            end else begin
               w_next = S_ISSUE;
            end
         end
         S_ABORT: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State, registered handshake outputs and command datapath.
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_cmd_abort <= 1'b0;
         r_arvalid   <= 1'b0;
         r_last      <= 1'b0;
         r_addr      <= {AXI_ADDR_WD{1'b0}};
         r_rem       <= {AXI_ADDR_WD{1'b0}};
         r_id        <= {AXI_ID_WD{1'b0}};
         r_burst     <= 2'b00;
         r_size      <= 3'd0;
         r_n         <= 9'd0;
         r_arlen     <= 8'd0;
      end else begin
         r_state     <= w_next;
         r_cmd_ready <= (w_next == S_IDLE);
         r_cmd_abort <= (w_next == S_ABORT);
         r_arvalid   <= (w_next == S_ISSUE);
         if (w_accept) begin
            r_addr  <= bus.cmd_addr;
            r_rem   <= bus.cmd_len;
            r_id    <= bus.cmd_id;
            r_burst <= bus.cmd_burst;
            r_size  <= bus.cmd_size;
         end
         if (r_state == S_CALC) begin
            r_n     <= w_n;
            r_arlen <= 8'(w_n - 9'd1);
            r_last  <= (r_rem == {{PADW{1'b0}}, w_n});
         end
         // Only a completed handshake moves the address, so the payload holds while stalled.
         if (w_hs) begin
            r_rem  <= r_rem - {{PADW{1'b0}}, r_n};
            r_addr <= w_next_addr;
         end
      end
   end

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.cmd_abort = r_cmd_abort;
   assign bus.cmd_done  = r_arvalid & bus.ARREADY & r_last & ~AXI_ARESET;
   assign bus.ARVALID   = r_arvalid;
   assign bus.ARADDR    = r_addr;
   assign bus.ARID      = r_id;
   assign bus.ARLEN     = r_arlen;
   assign bus.ARSIZE    = r_size;
   assign bus.ARBURST   = r_burst;
endmodule

// File: tb/tb_axi_cmd_splitter.sv
// Directed self-checking bench for axi_cmd_splitter.
module tb_axi_cmd_splitter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   axi_cmd_splitter_if #(.AXI_ID_WD(2), .AXI_ADDR_WD(16)) bus ();

   axi_cmd_splitter #(
      .AXI_ID_WD(2), .AXI_DATA_WD(32), .AXI_ADDR_WD(16),
      .AXI_STRB_WD(4), .MAX_BURST_LEN(256)
   ) dut (
      .AXI_ACLK  (clk),
      .AXI_ARESET(rst),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic issue_cmd(input logic [15:0] addr, input logic [1:0] id,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [15:0] len);
      int w;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_id    = id;
      bus.cmd_burst = burst;
      bus.cmd_size  = size;
      bus.cmd_len   = len;
      w = 0;
      while (bus.cmd_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (w >= 20) begin
         n_err++;
         $display("FAIL issue_wait: cmd_ready=%b required 1", bus.cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_ar(output int waits, output bit ok);
      waits = 0;
      while (bus.ARVALID !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      ok = (bus.ARVALID === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.cmd_ready, bus.cmd_abort, bus.cmd_done, bus.ARVALID} !== 4'b0000 ||
          bus.ARADDR !== 16'h0000 || bus.ARLEN !== 8'h00) begin
         n_err++;
         $display("FAIL reset_outputs: rdy/abt/done/vld=%b addr=%h len=%h required all 0",
                  {bus.cmd_ready, bus.cmd_abort, bus.cmd_done, bus.ARVALID},
                  bus.ARADDR, bus.ARLEN);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_basic();
      bus.ARREADY = 1'b1;
      issue_cmd(16'h0000, 2'd1, 2'b01, 3'd2, 16'd4);
      n_cmp++;
      if (bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL basic_t1: ARVALID=%b cmd_ready=%b required 0/0", bus.ARVALID, bus.cmd_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.ARVALID !== 1'b1 || bus.ARADDR !== 16'h0000 || bus.ARLEN !== 8'd3 ||
          bus.ARSIZE !== 3'd2 || bus.ARBURST !== 2'b01 || bus.ARID !== 2'd1) begin
         n_err++;
         $display("FAIL basic_ar: vld=%b addr=%h len=%0d size=%0d burst=%b id=%0d required 1/0000/3/2/01/1",
                  bus.ARVALID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARID);
      end
      n_cmp++;
      if (bus.cmd_done !== 1'b1) begin
         n_err++;
         $display("FAIL basic_done: cmd_done=%b required 1", bus.cmd_done);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.cmd_done !== 1'b0) begin
         n_err++;
         $display("FAIL basic_idle: vld=%b rdy=%b done=%b required 0/1/0",
                  bus.ARVALID, bus.cmd_ready, bus.cmd_done);
      end
   endtask

   task automatic test_4k_split();
      logic [15:0] exp_addr [5];
      logic [7:0]  exp_len  [5];
      int w;
      bit ok;
      exp_addr[0] = 16'h00FF; exp_len[0] = 8'd255;
      exp_addr[1] = 16'h04FC; exp_len[1] = 8'd255;
      exp_addr[2] = 16'h08FC; exp_len[2] = 8'd255;
      exp_addr[3] = 16'h0CFC; exp_len[3] = 8'd192;
      exp_addr[4] = 16'h1000; exp_len[4] = 8'd90;
      bus.ARREADY = 1'b1;
      issue_cmd(16'h00FF, 2'd0, 2'b01, 3'd2, 16'd1052);
      for (int k = 0; k < 5; k++) begin
         wait_ar(w, ok);
         n_cmp++;
         if (!ok || w != 1) begin
            n_err++;
            $display("FAIL 4k_gap[%0d]: waited %0d cycles ok=%0d required 1 cycle", k, w, ok);
         end
         n_cmp++;
         if (bus.ARADDR !== exp_addr[k] || bus.ARLEN !== exp_len[k]) begin
            n_err++;
            $display("FAIL 4k_ar[%0d]: addr=%h len=%0d required %h/%0d",
                     k, bus.ARADDR, bus.ARLEN, exp_addr[k], exp_len[k]);
         end
         n_cmp++;
         if (bus.cmd_done !== (k == 4)) begin
            n_err++;
            $display("FAIL 4k_done[%0d]: cmd_done=%b required %0d", k, bus.cmd_done, (k == 4));
         end
         @(negedge clk);
      end
      n_cmp++;
      if (bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL 4k_end: vld=%b rdy=%b required 0/1", bus.ARVALID, bus.cmd_ready);
      end
   endtask

   task automatic test_fixed();
      logic [7:0] exp_len [3];
      int w;
      bit ok;
      exp_len[0] = 8'd15; exp_len[1] = 8'd15; exp_len[2] = 8'd7;
      bus.ARREADY = 1'b1;
      issue_cmd(16'h0040, 2'd2, 2'b00, 3'd2, 16'd40);
      for (int k = 0; k < 3; k++) begin
         wait_ar(w, ok);
         n_cmp++;
         if (!ok || bus.ARADDR !== 16'h0040 || bus.ARLEN !== exp_len[k] ||
             bus.ARBURST !== 2'b00 || bus.ARID !== 2'd2) begin
            n_err++;
            $display("FAIL fixed_ar[%0d]: ok=%0d addr=%h len=%0d burst=%b id=%0d required 0040/%0d/00/2",
                     k, ok, bus.ARADDR, bus.ARLEN, bus.ARBURST, bus.ARID, exp_len[k]);
         end
         n_cmp++;
         if (bus.cmd_done !== (k == 2)) begin
            n_err++;
            $display("FAIL fixed_done[%0d]: cmd_done=%b required %0d", k, bus.cmd_done, (k == 2));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reject();
      logic [1:0]  burst [3];
      logic [2:0]  size  [3];
      logic [15:0] len   [3];
      burst[0] = 2'b01; size[0] = 3'd2; len[0] = 16'd0;
      burst[1] = 2'b10; size[1] = 3'd2; len[1] = 16'd4;
      burst[2] = 2'b01; size[2] = 3'd3; len[2] = 16'd4;
      bus.ARREADY = 1'b1;
      for (int k = 0; k < 3; k++) begin
         issue_cmd(16'h0100, 2'd1, burst[k], size[k], len[k]);
         n_cmp++;
         if (bus.cmd_abort !== 1'b1 || bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reject_t1[%0d]: abort=%b vld=%b rdy=%b required 1/0/0",
                     k, bus.cmd_abort, bus.ARVALID, bus.cmd_ready);
         end
         @(negedge clk);
         n_cmp++;
         if (bus.cmd_abort !== 1'b0 || bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reject_t2[%0d]: abort=%b vld=%b rdy=%b required 0/0/1",
                     k, bus.cmd_abort, bus.ARVALID, bus.cmd_ready);
         end
      end
   endtask

   task automatic test_backpressure_wrap();
      logic [15:0] exp_addr [2];
      int w;
      bit ok;
      exp_addr[0] = 16'hFFF0;
      exp_addr[1] = 16'h0000;
      bus.ARREADY = 1'b0;
      issue_cmd(16'hFFF0, 2'd3, 2'b01, 3'd2, 16'd8);
      for (int k = 0; k < 2; k++) begin
         wait_ar(w, ok);
         n_cmp++;
         if (!ok || bus.ARADDR !== exp_addr[k] || bus.ARLEN !== 8'd3 || bus.ARID !== 2'd3) begin
            n_err++;
            $display("FAIL bp_ar[%0d]: ok=%0d addr=%h len=%0d id=%0d required %h/3/3",
                     k, ok, bus.ARADDR, bus.ARLEN, bus.ARID, exp_addr[k]);
         end
         repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (bus.ARVALID !== 1'b1 || bus.ARADDR !== exp_addr[k] || bus.ARLEN !== 8'd3 ||
                bus.cmd_done !== 1'b0 || bus.cmd_ready !== 1'b0) begin
               n_err++;
               $display("FAIL bp_hold[%0d]: vld=%b addr=%h len=%0d done=%b rdy=%b required 1/%h/3/0/0",
                        k, bus.ARVALID, bus.ARADDR, bus.ARLEN, bus.cmd_done, bus.cmd_ready, exp_addr[k]);
            end
         end
         bus.ARREADY = 1'b1;
         #1;
         n_cmp++;
         if (bus.cmd_done !== (k == 1)) begin
            n_err++;
            $display("FAIL bp_done[%0d]: cmd_done=%b required %0d", k, bus.cmd_done, (k == 1));
         end
         @(negedge clk);
         bus.ARREADY = 1'b0;
      end
      n_cmp++;
      if (bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_end: vld=%b rdy=%b required 0/1", bus.ARVALID, bus.cmd_ready);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      bit ok;
      bus.ARREADY = 1'b0;
      issue_cmd(16'h0100, 2'd3, 2'b01, 3'd2, 16'd8);
      wait_ar(w, ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL rstmid_issue: ARVALID=%b required 1", bus.ARVALID);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.ARVALID !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.ARADDR !== 16'h0000) begin
         n_err++;
         $display("FAIL rstmid_drop: vld=%b rdy=%b addr=%h required 0/0/0000",
                  bus.ARVALID, bus.cmd_ready, bus.ARADDR);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.cmd_ready !== 1'b1 || bus.ARVALID !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_ready: rdy=%b vld=%b required 1/0", bus.cmd_ready, bus.ARVALID);
      end
      bus.ARREADY = 1'b1;
      issue_cmd(16'h0200, 2'd2, 2'b01, 3'd2, 16'd2);
      wait_ar(w, ok);
      n_cmp++;
      if (!ok || w != 1 || bus.ARADDR !== 16'h0200 || bus.ARLEN !== 8'd1 ||
          bus.ARID !== 2'd2 || bus.cmd_done !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_next: ok=%0d wait=%0d addr=%h len=%0d id=%0d done=%b required 1/1/0200/1/2/1",
                  ok, w, bus.ARADDR, bus.ARLEN, bus.ARID, bus.cmd_done);
      end
      @(negedge clk);
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 16'h0000;
      bus.cmd_id    = 2'd0;
      bus.cmd_burst = 2'b00;
      bus.cmd_size  = 3'd0;
      bus.cmd_len   = 16'd0;
      bus.ARREADY   = 1'b0;
      test_reset();
      test_basic();
      test_4k_split();
      test_fixed();
      test_reject();
      test_backpressure_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
